ucode_issue: RTL and testbench

- Microinstruction store and issue unit that sits opposite the micro-sequencer.
- Holds the microcode, looks up the word at the sequencer's current upc, and returns the sequencing fields (done, upc_up, upc_st, loop_0/1/2).
- Starts programs with a start_pos pulse and upc_start, and reports completion to the top level.
- Also forwards registered datapath control bits and counts run cycles.

---
 rtl/ucode_pkg.sv | 36 +++
 rtl/ucode_issue_if.sv | 31 +++
 rtl/ucode_store.sv | 28 ++
 rtl/ucode_issue.sv | 215 +++++++++++++++++++++
 tb/tb_ucode_issue.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucode_pkg.sv
// Shared definitions for the microinstruction store and issue unit.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package ucode_pkg;

    // Microinstruction field positions
    localparam int UI_DONE_BIT = 31;
    localparam int UI_UP_HI    = 30;
    localparam int UI_UP_LO    = 28;
    localparam int UI_ST_HI    = 27;
    localparam int UI_ST_LO    = 25;
    localparam int UI_DP_HI    = 24;
    localparam int UI_DP_LO    = 0;

    localparam int DP_W   = UI_DP_HI - UI_DP_LO + 1;
    localparam int LOOP_W = 11;

    // Issue FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_FIN   = 2'd3
    } issue_state_t;

    // Loop-count register select codes; code 3 selects nothing
    localparam logic [1:0] LOOP_SEL_0 = 2'd0;
    localparam logic [1:0] LOOP_SEL_1 = 2'd1;
    localparam logic [1:0] LOOP_SEL_2 = 2'd2;

    // Saturating 16-bit increment used by the run-cycle counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ucode_issue_if.sv
// Issue unit <-> micro-sequencer link: program start, current upc, sequencing fields.
// Latency: done/upc_up/upc_st are combinational from upc; start_pos/upc_start/loop_* are registered.
// Backpressure: none; the sequencer consumes one word per cycle while running.
interface ucode_issue_if #(
    parameter int AW = 8
);
    import ucode_pkg::*;

    logic              start_pos;   // one-cycle program start strobe
    logic [AW-1:0]     upc_start;   // program entry address, valid with start_pos
    logic [AW-1:0]     upc;         // sequencer's current microcode address
    logic              done;        // current word ends the program
    logic [2:0]        upc_up;      // loop-end markers of current word
    logic [2:0]        upc_st;      // loop-start markers of current word
    logic [LOOP_W-1:0] loop_0;      // loop iteration counts (0 means 2048)
    logic [LOOP_W-1:0] loop_1;
    logic [LOOP_W-1:0] loop_2;

    // Issue unit side
    modport master (
        output start_pos, upc_start, done, upc_up, upc_st, loop_0, loop_1, loop_2,
        input  upc
    );

    // Sequencer side
    modport slave (
        input  start_pos, upc_start, done, upc_up, upc_st, loop_0, loop_1, loop_2,
        output upc
    );

endinterface

// File: rtl/ucode_store.sv
// Microcode register array: synchronous write, asynchronous read, no reset.
// Latency: write visible on the cycle after we; read is combinational.
// Backpressure: none; a write is accepted every cycle we is high.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module ucode_store #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Contents survive reset on purpose: a re-run after reset uses the same program.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ucode_issue.sv
// Microinstruction store and issue unit: loads microcode, starts programs, feeds the sequencer.
// Latency: sequencing fields zero-latency from upc; dp_ctrl/dp_valid one cycle after each RUN cycle.
// Backpressure: load_ready gates load beats (IDLE, no start request, store not full); start_ack is combinational.
// Ports: clk/rstn; load_* microcode load stream; cfg_* loop-count writes; start_req/start_addr/start_ack,
//        finish, busy program control; dp_ctrl/dp_valid datapath bits; run_cycles; seq sequencer link.
module ucode_issue
    import ucode_pkg::*;
#(
    parameter int UINST_ADDR_WIDTH = 8,
    parameter int UINST_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rstn,

    input  logic                        load_clr,
    input  logic                        load_valid,
    input  logic [UINST_WIDTH-1:0]      load_data,
    output logic                        load_ready,

    input  logic                        cfg_we,
    input  logic [1:0]                  cfg_sel,
    input  logic [LOOP_W-1:0]           cfg_wdata,

    input  logic                        start_req,
    input  logic [UINST_ADDR_WIDTH-1:0] start_addr,
    output logic                        start_ack,
    output logic                        finish,
    output logic                        busy,

    output logic [DP_W-1:0]             dp_ctrl,
    output logic                        dp_valid,
    output logic [15:0]                 run_cycles,

    ucode_issue_if.master               seq
);

    localparam logic [UINST_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    issue_state_t                state_q;
    issue_state_t                state_d;

    logic [UINST_WIDTH-1:0]      rd_word;
    logic                        word_done;
    logic                        in_idle;
    logic                        in_run;
    logic                        cfg_open;

    logic [UINST_ADDR_WIDTH-1:0] load_ptr_q;
    logic                        full_q;
    logic                        load_beat;

    logic [UINST_ADDR_WIDTH-1:0] upc_start_q;
    logic [LOOP_W-1:0]           loop_0_q;
    logic [LOOP_W-1:0]           loop_1_q;
    logic [LOOP_W-1:0]           loop_2_q;

    logic [DP_W-1:0]             dp_ctrl_q;
    logic                        dp_valid_q;
    logic [15:0]                 run_cycles_q;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_run    = (state_q == ST_RUN);
    assign word_done = rd_word[UI_DONE_BIT];

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d   = ST_START;
                    start_ack = 1'b1;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (word_done) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign finish = (state_q == ST_FIN);
    assign busy   = !in_idle;

    // ------------------------------------------------------------------
    // Microcode loading: sequential fill from the load pointer, no wrap.
    // A pending start request closes the load port so a start never races
    // a write into the program it is about to run.
    // ------------------------------------------------------------------
    assign load_ready = in_idle & ~start_req & ~full_q;
    assign load_beat  = load_valid & load_ready & ~load_clr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_ptr_q <= '0;
            full_q     <= 1'b0;
        end else if (in_idle && load_clr) begin
            load_ptr_q <= '0;
            full_q     <= 1'b0;
        end else if (load_beat) begin
            if (load_ptr_q == LAST_ADDR) begin
                // Pointer parks on the last address; full blocks further beats.
                full_q <= 1'b1;
            end else begin
                load_ptr_q <= load_ptr_q + 1'b1;
            end
        end
    end

    ucode_store #(
        .AW (UINST_ADDR_WIDTH),
        .DW (UINST_WIDTH)
    ) u_store (
        .clk   (clk),
        .we    (load_beat),
        .waddr (load_ptr_q),
        .wdata (load_data),
        .raddr (seq.upc),
        .rdata (rd_word)
    );

    // ------------------------------------------------------------------
    // Program entry capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upc_start_q <= '0;
        end else if (in_idle && start_req) begin
            upc_start_q <= start_addr;
        end
    end

    // ------------------------------------------------------------------
    // Loop-count registers. Frozen while a program is starting or running
    // so the sequencer never sees a count change under a live loop.
    // ------------------------------------------------------------------
    assign cfg_open = (state_q != ST_START) && (state_q != ST_RUN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            loop_0_q <= '0;
            loop_1_q <= '0;
            loop_2_q <= '0;
        end else if (cfg_we && cfg_open) begin
            case (cfg_sel)
                LOOP_SEL_0: loop_0_q <= cfg_wdata;
                LOOP_SEL_1: loop_1_q <= cfg_wdata;
                LOOP_SEL_2: loop_2_q <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath control: registered copy of every RUN word, including the
    // final done word; forced to zero in any other cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_ctrl_q  <= '0;
            dp_valid_q <= 1'b0;
        end else begin
            dp_valid_q <= in_run;
            dp_ctrl_q  <= in_run ? rd_word[UI_DP_HI:UI_DP_LO] : '0;
        end
    end

    assign dp_ctrl  = dp_ctrl_q;
    assign dp_valid = dp_valid_q;

    // ------------------------------------------------------------------
    // Run-cycle counter: cleared on START, saturating count in RUN,
    // holds afterwards so software can read the last program's length.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_cycles_q <= '0;
        end else if (state_q == ST_START) begin
            run_cycles_q <= '0;
        end else if (in_run) begin
            run_cycles_q <= sat_inc16(run_cycles_q);
        end
    end

    assign run_cycles = run_cycles_q;

    // ------------------------------------------------------------------
    // Sequencer link. Sequencing fields are gated to RUN so an idle upc
    // (typically 0) can never end a program or move the sequencer.
    // ------------------------------------------------------------------
    assign seq.start_pos = (state_q == ST_START);
    assign seq.upc_start = upc_start_q;
    assign seq.done      = in_run & word_done;
    assign seq.upc_up    = in_run ? rd_word[UI_UP_HI:UI_UP_LO] : 3'b000;
    assign seq.upc_st    = in_run ? rd_word[UI_ST_HI:UI_ST_LO] : 3'b000;
    assign seq.loop_0    = loop_0_q;
    assign seq.loop_1    = loop_1_q;
    assign seq.loop_2    = loop_2_q;

endmodule

// File: tb/tb_ucode_issue.sv
module tb_ucode_issue;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        load_clr, load_valid, load_ready;
    logic [31:0] load_data;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [10:0] cfg_wdata;
    logic        start_req, start_ack, finish, busy;
    logic [7:0]  start_addr;
    logic [24:0] dp_ctrl;
    logic        dp_valid;
    logic [15:0] run_cycles;

    ucode_issue_if #(.AW(8)) seq_if ();

    ucode_issue #(
        .UINST_ADDR_WIDTH (8),
        .UINST_WIDTH      (32)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_clr   (load_clr),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .start_req  (start_req),
        .start_addr (start_addr),
        .start_ack  (start_ack),
        .finish     (finish),
        .busy       (busy),
        .dp_ctrl    (dp_ctrl),
        .dp_valid   (dp_valid),
        .run_cycles (run_cycles),
        .seq        (seq_if)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural micro-sequencer ----------------
    // Loads upc on start_pos, steps by one while running, resets upc to 0 on done.
    // upc_st[2]/upc_up[2] bracket a body executed loop_0 times (0 -> 2048).
    logic       seq_run, loop_act;
    int         loop_cnt;
    logic [7:0] loop_start;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seq_if.upc <= '0;
            seq_run    <= 1'b0;
            loop_act   <= 1'b0;
            loop_cnt   <= 0;
            loop_start <= '0;
        end else if (seq_if.start_pos) begin
            seq_if.upc <= seq_if.upc_start;
            seq_run    <= 1'b1;
            loop_act   <= 1'b0;
        end else if (seq_if.done) begin
            seq_if.upc <= '0;
            seq_run    <= 1'b0;
        end else if (seq_run) begin
            if (seq_if.upc_st[2] && !loop_act) begin
                loop_act   <= 1'b1;
                loop_cnt   <= (seq_if.loop_0 == 11'd0) ? 2048 : int'(seq_if.loop_0);
                loop_start <= seq_if.upc;
                seq_if.upc <= seq_if.upc + 8'd1;
            end else if (seq_if.upc_up[2] && loop_act && loop_cnt > 1) begin
                loop_cnt   <= loop_cnt - 1;
                seq_if.upc <= loop_start;
            end else begin
                if (seq_if.upc_up[2]) loop_act <= 1'b0;
                seq_if.upc <= seq_if.upc + 8'd1;
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [31:0] mem_model [256];
    logic [31:0] image [256];
    int          mptr;
    bit          mfull;
    logic [10:0] loop_model [3];
    int          exp_upc [$];

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          we;
        logic [1:0]  sel;
        logic [10:0] wd;
        logic [10:0] e0, e1, e2;
    } cfg_vec_t;
    cfg_vec_t cv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected upc trace of a program: walk the store image from sa until a done word.
    function automatic void build_trace(input int sa);
        int a, ls, rem, guard;
        logic [31:0] w;
        exp_upc.delete();
        a = sa; ls = -1; rem = 0; guard = 0;
        while (guard < 4096) begin
            guard++;
            exp_upc.push_back(a);
            w = mem_model[a];
            if (w[31]) break;
            if (w[27] && ls < 0) begin
                ls  = a;
                rem = ((loop_model[0] == 11'd0) ? 2048 : int'(loop_model[0])) - 1;
            end
            if (w[30] && ls >= 0) begin
                if (rem > 0) begin
                    rem--;
                    a = ls;
                    continue;
                end
                ls = -1;
            end
            a = (a + 1) % 256;
        end
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".start_ack"},  start_ack, 0);
        chk({tag, ".finish"},     finish, 0);
        chk({tag, ".busy"},       busy, 0);
        chk({tag, ".start_pos"},  seq_if.start_pos, 0);
        chk({tag, ".upc_start"},  seq_if.upc_start, 0);
        chk({tag, ".done"},       seq_if.done, 0);
        chk({tag, ".upc_up"},     seq_if.upc_up, 0);
        chk({tag, ".upc_st"},     seq_if.upc_st, 0);
        chk({tag, ".loop_0"},     seq_if.loop_0, 0);
        chk({tag, ".loop_1"},     seq_if.loop_1, 0);
        chk({tag, ".loop_2"},     seq_if.loop_2, 0);
        chk({tag, ".dp_ctrl"},    dp_ctrl, 0);
        chk({tag, ".dp_valid"},   dp_valid, 0);
        chk({tag, ".run_cycles"}, run_cycles, 0);
    endtask

    // One load cycle in IDLE; model decides readiness and whether the word lands.
    task automatic beat(input logic [31:0] d, input bit v, input bit clr, input string tag);
        bit exp_rdy;
        @(negedge clk);
        load_valid = v; load_data = d; load_clr = clr;
        #1;
        exp_rdy = !mfull;
        chk({tag, ".load_ready"}, load_ready, exp_rdy);
        if (clr) begin
            mptr = 0; mfull = 0;
        end else if (v && exp_rdy) begin
            mem_model[mptr] = d;
            if (mptr == 255) mfull = 1; else mptr++;
        end
        @(posedge clk);
        #1;
        load_valid = 0; load_clr = 0;
    endtask

    // Start a program at sa and check every cycle against exp_upc / mem_model.
    task automatic run_prog(input logic [7:0] sa, input bit with_load, input bit cfg_in_run, input string tag);
        int n;
        logic [31:0] w;
        n = exp_upc.size();
        @(negedge clk);
        start_req = 1; start_addr = sa; load_clr = 0;
        load_valid = with_load; load_data = 32'h8000_0BAD;
        #1;
        chk({tag, ".ack"}, start_ack, 1);
        chk({tag, ".idle_busy"}, busy, 0);
        if (with_load) chk({tag, ".load_ready_sreq"}, load_ready, 0);
        @(negedge clk);
        start_req = 0; load_valid = 0;
        if (cfg_in_run) begin cfg_we = 1; cfg_sel = 2'd2; cfg_wdata = 11'd9; end
        #1;
        chk({tag, ".ack_pulse"}, start_ack, 0);
        chk({tag, ".start_pos"}, seq_if.start_pos, 1);
        chk({tag, ".upc_start"}, seq_if.upc_start, sa);
        chk({tag, ".start_busy"}, busy, 1);
        chk({tag, ".start_done"}, seq_if.done, 0);
        chk({tag, ".start_up_st"}, {seq_if.upc_up, seq_if.upc_st}, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 1) cfg_we = 0;
            #1;
            w = mem_model[exp_upc[i]];
            chk($sformatf("%s.upc[%0d]", tag, i), seq_if.upc, exp_upc[i]);
            chk($sformatf("%s.done[%0d]", tag, i), seq_if.done, w[31]);
            chk($sformatf("%s.upc_up[%0d]", tag, i), seq_if.upc_up, w[30:28]);
            chk($sformatf("%s.upc_st[%0d]", tag, i), seq_if.upc_st, w[27:25]);
            chk($sformatf("%s.pos_pulse[%0d]", tag, i), seq_if.start_pos, 0);
            chk($sformatf("%s.fin[%0d]", tag, i), finish, 0);
            chk($sformatf("%s.dp_valid[%0d]", tag, i), dp_valid, (i > 0));
            chk($sformatf("%s.dp_ctrl[%0d]", tag, i), dp_ctrl,
                (i > 0) ? {7'd0, mem_model[exp_upc[i-1]][24:0]} : 32'd0);
            chk($sformatf("%s.run_cycles[%0d]", tag, i), run_cycles, i);
        end
        @(negedge clk);
        cfg_we = 0;
        #1;
        chk({tag, ".finish"}, finish, 1);
        chk({tag, ".fin_busy"}, busy, 1);
        chk({tag, ".fin_done"}, seq_if.done, 0);
        chk({tag, ".fin_dp_valid"}, dp_valid, 1);
        chk({tag, ".fin_dp_ctrl"}, dp_ctrl, {7'd0, mem_model[exp_upc[n-1]][24:0]});
        chk({tag, ".fin_run_cycles"}, run_cycles, n);
        @(negedge clk);
        #1;
        chk({tag, ".finish_pulse"}, finish, 0);
        chk({tag, ".end_busy"}, busy, 0);
        chk({tag, ".end_dp_valid"}, dp_valid, 0);
        chk({tag, ".end_dp_ctrl"}, dp_ctrl, 0);
        chk({tag, ".hold_run_cycles"}, run_cycles, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p1 [4];
        int          lp [7];
        logic [31:0] p2 [4];
        bit          found;

        p1 = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0002, 32'h8000_0003};
        p2 = '{32'h0000_0004, 32'h0800_0005, 32'h4000_0006, 32'h8000_0007};
        lp = '{5, 6, 5, 6, 5, 6, 7};
        cv[0] = '{1'b1, 2'd0, 11'd3,    11'd3, 11'd0,   11'd0};
        cv[1] = '{1'b1, 2'd1, 11'd100,  11'd3, 11'd100, 11'd0};
        cv[2] = '{1'b1, 2'd2, 11'd2047, 11'd3, 11'd100, 11'd2047};
        cv[3] = '{1'b1, 2'd3, 11'd55,   11'd3, 11'd100, 11'd2047};
        cv[4] = '{1'b0, 2'd0, 11'd77,   11'd3, 11'd100, 11'd2047};
        cv[5] = '{1'b1, 2'd2, 11'd0,    11'd3, 11'd100, 11'd0};
        cv[6] = '{1'b1, 2'd2, 11'd5,    11'd3, 11'd100, 11'd5};

        load_clr = 0; load_valid = 0; load_data = '0;
        cfg_we = 0; cfg_sel = '0; cfg_wdata = '0;
        start_req = 0; start_addr = '0;
        mptr = 0; mfull = 0;
        loop_model[0] = '0; loop_model[1] = '0; loop_model[2] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        rstn = 1;

        // Short program 1,2,3
        for (int i = 0; i < 4; i++) beat(p1[i], 1, 0, $sformatf("p1_load%0d", i));
        exp_upc.delete();
        for (int i = 1; i <= 3; i++) exp_upc.push_back(i);
        run_prog(8'd1, 0, 0, "prog123");

        // Idle with a done word at address 0: nothing may leak to the sequencer
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle.done[%0d]", i), seq_if.done, 0);
            chk($sformatf("idle.upc[%0d]", i), seq_if.upc, 0);
        end

        // Loop-count register table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cfg_we = cv[i].we; cfg_sel = cv[i].sel; cfg_wdata = cv[i].wd;
            @(negedge clk);
            cfg_we = 0;
            #1;
            chk($sformatf("cfg[%0d].loop_0", i), seq_if.loop_0, cv[i].e0);
            chk($sformatf("cfg[%0d].loop_1", i), seq_if.loop_1, cv[i].e1);
            chk($sformatf("cfg[%0d].loop_2", i), seq_if.loop_2, cv[i].e2);
        end
        loop_model[0] = cv[6].e0; loop_model[1] = cv[6].e1; loop_model[2] = cv[6].e2;

        // Loop program 5,6 x3 then 7
        for (int i = 0; i < 4; i++) beat(p2[i], 1, 0, $sformatf("p2_load%0d", i));
        exp_upc.delete();
        foreach (lp[i]) exp_upc.push_back(lp[i]);
        run_prog(8'd5, 0, 0, "loop");

        // Start beats load; cfg writes in START/RUN are dropped
        exp_upc.delete();
        for (int i = 1; i <= 3; i++) exp_upc.push_back(i);
        run_prog(8'd1, 1, 1, "sreq_load");
        chk("run_cfg_ignored.loop_2", seq_if.loop_2, loop_model[2]);
        beat(32'h8000_0088, 1, 0, "after_sreq_load");
        build_trace(8);
        run_prog(8'd8, 0, 0, "ptr_check");

        // Full 256-word load and its boundaries
        for (int a = 0; a < 256; a++) begin
            bit dn;
            dn = (a % 16 == 15) || ($urandom_range(0, 7) == 0);
            if (a >= 32 && a <= 46) dn = 0;
            image[a] = {dn, 6'b0, 25'($urandom)};
        end
        beat(32'h0, 0, 1, "pre_clr");
        for (int a = 0; a < 256; a++) beat(image[a], 1, 0, $sformatf("full_load%0d", a));
        beat(32'hDEAD_BEEF, 1, 0, "beat257");
        build_trace(0);
        run_prog(8'd0, 0, 0, "addr0_after_full");
        beat(32'h0, 0, 1, "clr_when_full");
        beat(32'h8000_1234, 1, 1, "clr_with_beat");
        build_trace(0);
        run_prog(8'd0, 0, 0, "addr0_after_clr_beat");

        // Randomised programs against the image
        for (int k = 0; k < 8; k++) begin
            int sa;
            sa = $urandom_range(0, 255);
            build_trace(sa);
            run_prog(8'(sa), 0, 0, $sformatf("rand%0d", k));
        end

        // Reset in the middle of a run at upc=40
        @(negedge clk);
        start_req = 1; start_addr = 8'd33;
        @(negedge clk);
        start_req = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (seq_if.upc == 8'd40 && busy) found = 1;
        end
        chk("midrst.reach_upc40", found, 1);
        rstn = 0;
        @(negedge clk);
        #1;
        chk_zero("midrst");
        rstn = 1;
        mptr = 0; mfull = 0;
        loop_model[0] = '0; loop_model[1] = '0; loop_model[2] = '0;
        build_trace(33);
        run_prog(8'd33, 0, 0, "rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
